// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: maps VGA timing coordinates to a downscaled framebuffer
// address and rotates through NUM_BUFS display buffers, either on a frame
// timer (auto mode) or on a renderer swap handshake (manual mode).
module pixel_addr_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int V_LAST         = 524,
    parameter int SCALE_SHIFT    = 2,
    parameter int NUM_BUFS       = 2,
    parameter int FRAMES_PER_BUF = 16,
    parameter int ADDR_W         = 16,
    localparam int BUF_W         = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic              auto_mode,
    input  logic              swap_req,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic [BUF_W-1:0]  buf_idx,
    output logic [7:0]        frame_cnt,
    output logic              frame_tick,
    output logic              swap_ack
);

    localparam int SW       = H_ACTIVE >> SCALE_SHIFT;
    localparam int SH       = V_ACTIVE >> SCALE_SHIFT;
    localparam int BUF_SIZE = SW * SH;
    localparam int HOLD_W   = (FRAMES_PER_BUF > 1) ? $clog2(FRAMES_PER_BUF) : 1;

    localparam logic [ADDR_W-1:0] SW_A       = ADDR_W'(SW);
    localparam logic [ADDR_W-1:0] BUF_SIZE_A = ADDR_W'(BUF_SIZE);
    // 11-bit limits so a 1024-wide active region still compares correctly
    localparam logic [10:0]       H_LIM      = 11'(H_ACTIVE);
    localparam logic [10:0]       V_LIM      = 11'(V_ACTIVE);
    localparam logic [9:0]        V_LAST_L   = 10'(V_LAST);
    localparam logic [HOLD_W-1:0] HOLD_END   = HOLD_W'(FRAMES_PER_BUF - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = {HOLD_W{1'b1}};
    localparam logic [BUF_W-1:0]  BUF_LAST   = BUF_W'(NUM_BUFS - 1);

    logic [ADDR_W-1:0] address_q;
    logic              addr_valid_q;
    logic [BUF_W-1:0]  buf_idx_q;
    logic [7:0]        frame_cnt_q;
    logic              frame_tick_q;
    logic              swap_ack_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              last_line_q;

    logic              active;
    logic              on_last;
    logic              frame_ev;
    logic              hold_done;
    logic [ADDR_W-1:0] pix_addr;
    logic [BUF_W-1:0]  buf_next;

    // Pixel classification, address arithmetic and frame-boundary detection
    always_comb begin
        active    = ({1'b0, xpos} < H_LIM) && ({1'b0, ypos} < V_LIM);
        pix_addr  = ADDR_W'(buf_idx_q) * BUF_SIZE_A
                  + ADDR_W'(ypos >> SCALE_SHIFT) * SW_A
                  + ADDR_W'(xpos >> SCALE_SHIFT);
        on_last   = (ypos == V_LAST_L);
        // only the first strobe on the boundary line counts as the frame event
        frame_ev  = pix_en && on_last && !last_line_q;
        // >= keeps auto mode from stalling if manual mode left hold_cnt high
        hold_done = (hold_cnt_q >= HOLD_END);
        buf_next  = (buf_idx_q == BUF_LAST) ? '0 : buf_idx_q + BUF_W'(1);
    end

    // Registered address, frame counting and buffer rotation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_q    <= '0;
            addr_valid_q <= 1'b0;
            buf_idx_q    <= '0;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            hold_cnt_q   <= '0;
            last_line_q  <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            if (pix_en) begin
                address_q    <= active ? pix_addr : '0;
                addr_valid_q <= active;
                last_line_q  <= on_last;
                if (frame_ev) begin
                    frame_tick_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 8'd1;
                    if (auto_mode) begin
                        if (hold_done) begin
                            buf_idx_q  <= buf_next;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end else if (swap_req) begin
                        buf_idx_q  <= buf_next;
                        swap_ack_q <= 1'b1;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
        end
    end

    assign address    = address_q;
    assign addr_valid = addr_valid_q;
    assign buf_idx    = buf_idx_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_tick = frame_tick_q;
    assign swap_ack   = swap_ack_q;

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Bench for pixel_addr_gen: default instance checked against a behavioural
// model plus directed cases; a 3-buffer, 2x-scale instance for wide addresses.
module tb_pixel_addr_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pix_en = 1'b0;
    logic [9:0] xpos = '0;
    logic [9:0] ypos = '0;
    logic       auto_mode = 1'b0;
    logic       swap_req = 1'b0;

    logic [15:0] a_address;
    logic        a_addr_valid;
    logic [0:0]  a_buf_idx;
    logic [7:0]  a_frame_cnt;
    logic        a_frame_tick;
    logic        a_swap_ack;

    logic [17:0] b_address;
    logic        b_addr_valid;
    logic [1:0]  b_buf_idx;
    logic [7:0]  b_frame_cnt;
    logic        b_frame_tick;
    logic        b_swap_ack;

    int checks = 0;
    int errors = 0;
    int a_ticks = 0;
    int a_acks = 0;

    // behavioural model of the default instance
    int m_addr, m_buf, m_fcnt, m_hold;
    bit m_valid, m_tick, m_ack, m_prev_last;

    pixel_addr_gen dut_a (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .xpos(xpos), .ypos(ypos),
        .auto_mode(auto_mode), .swap_req(swap_req),
        .address(a_address), .addr_valid(a_addr_valid), .buf_idx(a_buf_idx),
        .frame_cnt(a_frame_cnt), .frame_tick(a_frame_tick), .swap_ack(a_swap_ack)
    );

    pixel_addr_gen #(.SCALE_SHIFT(1), .NUM_BUFS(3), .ADDR_W(18)) dut_b (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .xpos(xpos), .ypos(ypos),
        .auto_mode(auto_mode), .swap_req(swap_req),
        .address(b_address), .addr_valid(b_addr_valid), .buf_idx(b_buf_idx),
        .frame_cnt(b_frame_cnt), .frame_tick(b_frame_tick), .swap_ack(b_swap_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_addr = 0; m_buf = 0; m_fcnt = 0; m_hold = 0;
        m_valid = 0; m_tick = 0; m_ack = 0; m_prev_last = 0;
    endtask

    // one strobe of the default configuration, straight from the rules:
    // 640x480 active, /4 scale, 160-wide buffers of 19200 words, 2 buffers,
    // 16 frames per buffer, frame event = first strobe on line 524
    task automatic model_step();
        bit act, last;
        m_tick = 0;
        m_ack  = 0;
        if (pix_en) begin
            act     = (int'(xpos) < 640) && (int'(ypos) < 480);
            m_addr  = act ? m_buf * 19200 + (int'(ypos) / 4) * 160 + int'(xpos) / 4 : 0;
            m_valid = act;
            last    = (int'(ypos) == 524);
            if (last && !m_prev_last) begin
                m_tick = 1;
                m_fcnt = (m_fcnt + 1) % 256;
                if (auto_mode) begin
                    if (m_hold >= 15) begin m_buf = (m_buf + 1) % 2; m_hold = 0; end
                    else m_hold++;
                end else if (swap_req) begin
                    m_buf = (m_buf + 1) % 2; m_ack = 1; m_hold = 0;
                end else begin
                    m_hold++;
                end
            end
            m_prev_last = last;
        end
    endtask

    // advance one clock; inputs change only around the falling edge
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_clear(); else model_step();
        @(negedge clk);
        a_ticks += int'(a_frame_tick);
        a_acks  += int'(a_swap_ack);
    endtask

    task automatic set_pix(input int x, input int y, input bit en);
        xpos = 10'(x); ypos = 10'(y); pix_en = en;
    endtask

    task automatic frame_event();
        set_pix(0, 524, 1); tick();
        set_pix(0, 0, 1);   tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        model_clear();
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        checks++; if (a_address !== 16'd0)  begin errors++; $display("FAIL reset_addr got %0d exp 0", a_address); end
        checks++; if (a_addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", a_addr_valid); end
        checks++; if (a_buf_idx !== 1'b0)    begin errors++; $display("FAIL reset_buf got %0d exp 0", a_buf_idx); end
        checks++; if (a_frame_cnt !== 8'd0)  begin errors++; $display("FAIL reset_fcnt got %0d exp 0", a_frame_cnt); end
        checks++; if (a_frame_tick !== 1'b0 || a_swap_ack !== 1'b0) begin errors++; $display("FAIL reset_pulses got %0b%0b exp 00", a_frame_tick, a_swap_ack); end
        checks++; if (b_address !== 18'd0 || b_buf_idx !== 2'd0) begin errors++; $display("FAIL reset_b got addr %0d buf %0d exp 0 0", b_address, b_buf_idx); end
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_addr_map();
        int xs[4] = '{0, 4, 639, 640};
        int ys[4] = '{0, 4, 479, 0};
        int ea[4] = '{0, 161, 19199, 0};
        bit ev[4] = '{1, 1, 1, 0};
        auto_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_pix(xs[i], ys[i], 1);
            tick();
            checks++; if (a_address !== 16'(ea[i])) begin errors++; $display("FAIL map_addr (%0d,%0d) got %0d exp %0d", xs[i], ys[i], a_address, ea[i]); end
            checks++; if (a_addr_valid !== ev[i])   begin errors++; $display("FAIL map_valid (%0d,%0d) got %0b exp %0b", xs[i], ys[i], a_addr_valid, ev[i]); end
        end
    endtask

    task automatic test_auto_cycle();
        a_ticks = 0;
        auto_mode = 1'b1;
        for (int i = 0; i < 15; i++) frame_event();
        checks++; if (a_buf_idx !== 1'b0) begin errors++; $display("FAIL auto_buf15 got %0d exp 0", a_buf_idx); end
        frame_event();
        checks++; if (a_buf_idx !== 1'b1) begin errors++; $display("FAIL auto_buf16 got %0d exp 1", a_buf_idx); end
        set_pix(0, 0, 1); tick();
        checks++; if (a_address !== 16'h4B00) begin errors++; $display("FAIL auto_base got %0h exp 4b00", a_address); end
        for (int i = 0; i < 16; i++) frame_event();
        checks++; if (a_buf_idx !== 1'b0)    begin errors++; $display("FAIL auto_buf32 got %0d exp 0", a_buf_idx); end
        checks++; if (a_frame_cnt !== 8'd32) begin errors++; $display("FAIL auto_fcnt got %0d exp 32", a_frame_cnt); end
        checks++; if (a_ticks !== 32)        begin errors++; $display("FAIL auto_ticks got %0d exp 32", a_ticks); end
    endtask

    task automatic test_boundary_hold();
        a_ticks = 0;
        for (int i = 0; i < 800; i++) begin set_pix(i, 524, 1); tick(); end
        set_pix(0, 0, 1); tick();
        checks++; if (a_ticks !== 1)         begin errors++; $display("FAIL hold_ticks got %0d exp 1", a_ticks); end
        checks++; if (a_frame_cnt !== 8'd33) begin errors++; $display("FAIL hold_fcnt got %0d exp 33", a_frame_cnt); end
        set_pix(8, 8, 1); tick();
        checks++; if (a_address !== 16'd322) begin errors++; $display("FAIL hold_pre got %0d exp 322", a_address); end
        for (int i = 0; i < 10; i++) begin
            set_pix($urandom_range(0, 799), $urandom_range(0, 524), 0);
            tick();
            checks++; if (a_address !== 16'd322 || a_addr_valid !== 1'b1) begin errors++; $display("FAIL hold_addr cyc %0d got %0d/%0b exp 322/1", i, a_address, a_addr_valid); end
        end
    endtask

    task automatic test_manual();
        auto_mode = 1'b0;
        swap_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_pix(i * 8, 100, 1); tick();
            checks++; if (a_swap_ack !== 1'b0 || a_buf_idx !== 1'b0) begin errors++; $display("FAIL man_wait cyc %0d got ack %0b buf %0d exp 0 0", i, a_swap_ack, a_buf_idx); end
        end
        set_pix(0, 524, 1); tick();
        checks++; if (a_swap_ack !== 1'b1)   begin errors++; $display("FAIL man_ack got %0b exp 1", a_swap_ack); end
        checks++; if (a_buf_idx !== 1'b1)    begin errors++; $display("FAIL man_buf got %0d exp 1", a_buf_idx); end
        checks++; if (a_frame_tick !== 1'b1) begin errors++; $display("FAIL man_tick got %0b exp 1", a_frame_tick); end
        swap_req = 1'b0;
        set_pix(0, 0, 1); tick();
        checks++; if (a_swap_ack !== 1'b0)   begin errors++; $display("FAIL man_ack_pulse got %0b exp 0", a_swap_ack); end
        checks++; if (a_address !== 16'h4B00) begin errors++; $display("FAIL man_base got %0h exp 4b00", a_address); end
        a_acks = 0;
        for (int i = 0; i < 5; i++) frame_event();
        checks++; if (a_acks !== 0 || a_buf_idx !== 1'b1) begin errors++; $display("FAIL man_noreq got acks %0d buf %0d exp 0 1", a_acks, a_buf_idx); end
    endtask

    task automatic test_three_bufs();
        int eb[3] = '{1, 2, 0};
        do_reset();
        auto_mode = 1'b0;
        swap_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_pix(0, 524, 1); tick();
            checks++; if (b_buf_idx !== 2'(eb[k]) || b_swap_ack !== 1'b1) begin errors++; $display("FAIL b_swap %0d got buf %0d ack %0b exp %0d 1", k, b_buf_idx, b_swap_ack, eb[k]); end
            checks++; if (a_buf_idx !== 1'(m_buf)) begin errors++; $display("FAIL a_swap %0d got buf %0d exp %0d", k, a_buf_idx, m_buf); end
            set_pix(0, 0, 1); tick();
            checks++; if (b_swap_ack !== 1'b0) begin errors++; $display("FAIL b_ack_pulse %0d got %0b exp 0", k, b_swap_ack); end
            if (k == 1) begin
                set_pix(2, 2, 1); tick();
                checks++; if (b_address !== 18'd153921 || b_addr_valid !== 1'b1) begin errors++; $display("FAIL b_addr got %0d/%0b exp 153921/1", b_address, b_addr_valid); end
            end
        end
        swap_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_mode = 1'b0;
        swap_req  = 1'b1;
        frame_event();
        swap_req = 1'b0;
        for (int i = 0; i < 6; i++) frame_event();
        checks++; if (a_buf_idx !== 1'b1 || a_frame_cnt !== 8'd7) begin errors++; $display("FAIL rmid_pre got buf %0d fcnt %0d exp 1 7", a_buf_idx, a_frame_cnt); end
        set_pix(200, 200, 1); tick();
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        checks++; if (a_address !== 16'd0 || a_addr_valid !== 1'b0 || a_buf_idx !== 1'b0 || a_frame_cnt !== 8'd0 || a_frame_tick !== 1'b0 || a_swap_ack !== 1'b0)
            begin errors++; $display("FAIL rmid_async got addr %0d v %0b buf %0d fcnt %0d exp all 0", a_address, a_addr_valid, a_buf_idx, a_frame_cnt); end
        tick();
        reset_n = 1'b1;
        set_pix(0, 0, 1); tick();
        frame_event();
        checks++; if (a_frame_cnt !== 8'd1) begin errors++; $display("FAIL rmid_fcnt got %0d exp 1", a_frame_cnt); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 4000; c++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 3)      ypos = 10'd524;
            else if (r < 5) ypos = 10'd523;
            else            ypos = 10'($urandom_range(0, 524));
            xpos = 10'($urandom_range(0, 799));
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 7) == 0)  swap_req  = ~swap_req;
            tick();
            checks++; if (a_address !== 16'(m_addr) || a_addr_valid !== m_valid) begin errors++; $display("FAIL rand_addr cyc %0d got %0d/%0b exp %0d/%0b", c, a_address, a_addr_valid, m_addr, m_valid); end
            checks++; if (a_buf_idx !== 1'(m_buf) || a_frame_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL rand_state cyc %0d got buf %0d fcnt %0d exp %0d %0d", c, a_buf_idx, a_frame_cnt, m_buf, m_fcnt); end
            checks++; if (a_frame_tick !== m_tick || a_swap_ack !== m_ack) begin errors++; $display("FAIL rand_pulse cyc %0d got tick %0b ack %0b exp %0b %0b", c, a_frame_tick, a_swap_ack, m_tick, m_ack); end
        end
    endtask

    initial begin
        test_reset();
        test_addr_map();
        test_auto_cycle();
        test_boundary_hold();
        test_manual();
        test_three_bufs();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
